march_bist_ctrl: RTL
====================

MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-low reset; clock clk.
REQ-003 SHALL have port start, input, 1, single-cycle request to run March C-; sampled only in IDLE or DONE.
REQ-004 SHALL have port busy, output, 1, high from the cycle after start is accepted until DONE is entered.
REQ-005 SHALL have port done, output, 1, level-high in DONE until the next accepted start or reset.
REQ-006 SHALL have ports mem_addr (output, 4), mem_wdata (output, 2), mem_we_n (output, 1), mem_cs_n (output, 1), the SRAM command bus.
REQ-007 SHALL have port mem_rdata, input, 2, SRAM read data, valid one cycle after a read command.
REQ-008 SHALL have port fail, output, 1, sticky mismatch flag for the current run.
REQ-009 SHALL have ports fail_addr (output, 4), first failing address, and fail_cnt (output, 5), saturating mismatch count.

Function
REQ-010 SHALL execute March C-, one SRAM operation per cycle: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-011 SHALL encode data "0" as 2'b00 and "1" as 2'b11.
REQ-012 SHALL use FSM states IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
REQ-013 SHALL go from IDLE/DONE to M0 on start=1, clearing fail, fail_addr, fail_cnt and done.
REQ-014 SHALL run ascending elements from address 0 to 15 and descending elements from 15 to 0.
REQ-015 SHALL, in M1-M4, issue the read then the write to the same address on consecutive cycles, advancing the address after the write.
REQ-016 SHALL move to the next element in the cycle after the last operation at the end address (15 up, 0 down); address wrap SHALL never occur inside an element.
REQ-017 SHALL take exactly 160 operation cycles (16+4x32+16), then one DRAIN cycle, then DONE.
REQ-018 SHALL, for a start accepted at edge 0, drive operations on cycles 1..160, DRAIN on 161 and done=1 from 162.
REQ-019 SHALL drive write commands as mem_cs_n=0, mem_we_n=0 and read commands as mem_cs_n=0, mem_we_n=1.
REQ-020 SHALL hold mem_cs_n=1, mem_we_n=1, mem_addr=0, mem_wdata=0 in IDLE, DRAIN and DONE.
REQ-021 SHALL register the expected data and address of each read and compare them against mem_rdata on the following cycle.
REQ-022 SHALL update fail, fail_addr and fail_cnt on the edge after a mismatching mem_rdata is sampled.
REQ-023 SHALL never compare on write cycles or on cycles with no operation.
REQ-024 SHALL capture fail_addr only on the first mismatch of a run.
REQ-025 SHALL saturate fail_cnt at 31.
REQ-026 SHALL ignore start while busy=1.

Reset
REQ-027 SHALL force, on rst=0 at a clock edge, state=IDLE, busy=0, done=0, fail=0, fail_addr=0, fail_cnt=0 and the command bus idle per REQ-020, including when the reset lands mid-run.
REQ-028 SHALL discard any pending compare on reset.

Configuration
REQ-029 SHALL use macro MARCH_FAIL_LOG_EN.
REQ-030 SHALL, when MARCH_FAIL_LOG_EN is defined, implement fail_addr and fail_cnt per REQ-022, REQ-024 and REQ-025.
REQ-031 SHALL, when MARCH_FAIL_LOG_EN is undefined, tie fail_addr and fail_cnt to 0 while fail remains functional.

Structure
REQ-032 SHALL place ADDR_W=4, DATA_W=2, NUM_WORDS=16, BG0=2'b00, BG1=2'b11 and the FSM state enum in shared package march_pkg.
REQ-033 SHALL implement the read-compare pipeline and fail logging in one sub-module, march_cmp; sequencing SHALL stay in march_bist_ctrl.

Verification
REQ-034 SHALL verify: fault-free SRAM model, start pulse -> done=1 exactly 162 cycles after start, fail=0, fail_cnt=0.
REQ-035 SHALL verify: bit 0 of address 5 stuck-at-1 -> fail=1, fail_addr=5, fail_cnt=3 (the r0 reads of M1, M3, M5).
REQ-036 SHALL verify: command trace check -> 16 writes of 2'b00, then M1 starts at cycle 17 with a read at address 0; M3 starts at cycle 81 with a read at address 15.
REQ-037 SHALL verify: rst=0 at cycle 70 mid-run -> next cycle busy=0, mem_cs_n=1, fail=0; a new start then completes normally.
REQ-038 SHALL verify: start pulsed at cycle 50 during a run -> ignored, done still at cycle 162.
REQ-039 SHALL verify: build without MARCH_FAIL_LOG_EN plus the stuck-at fault of REQ-035 -> fail=1, fail_addr=0, fail_cnt=0.

Source files
------------

// File: rtl/march_pkg.sv
// Shared types and constants for the March C- BIST controller.
// Optional MARCH_FAIL_LOG_EN adds the failing-address/count log in march_cmp.
package march_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 2;
    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned CNT_W     = 5;

    localparam logic [DATA_W-1:0] BG0 = 2'b00;
    localparam logic [DATA_W-1:0] BG1 = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [3:0] {
        StIdle,
        StM0,
        StM1,
        StM2,
        StM3,
        StM4,
        StM5,
        StDrain,
        StDone
    } march_state_e;

    function automatic logic elem_down(input march_state_e s);
        return (s == StM3) || (s == StM4);
    endfunction

    function automatic logic elem_has_read(input march_state_e s);
        return (s == StM1) || (s == StM2) || (s == StM3) || (s == StM4) || (s == StM5);
    endfunction

    function automatic logic elem_has_write(input march_state_e s);
        return (s == StM0) || (s == StM1) || (s == StM2) || (s == StM3) || (s == StM4);
    endfunction

    function automatic logic [DATA_W-1:0] read_bg(input march_state_e s);
        return ((s == StM2) || (s == StM4)) ? BG1 : BG0;
    endfunction

    function automatic logic [DATA_W-1:0] write_bg(input march_state_e s);
        return ((s == StM1) || (s == StM3)) ? BG1 : BG0;
    endfunction

    function automatic march_state_e next_elem(input march_state_e s);
        march_state_e n;
        case (s)
            StM0:    n = StM1;
            StM1:    n = StM2;
            StM2:    n = StM3;
            StM3:    n = StM4;
            StM4:    n = StM5;
            default: n = StDrain;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/march_cmp.sv
// Read-compare pipeline: registers each read's expectation, checks it a cycle later.
// With MARCH_FAIL_LOG_EN defined, also logs the first failing address and a saturating count.
module march_cmp
    import march_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
);

    logic              pend_q;
    logic [DATA_W-1:0] exp_q;
    logic              fail_q;
    logic              mismatch;

    assign mismatch = pend_q && (mem_rdata != exp_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q <= 1'b0;
            exp_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            pend_q <= rd_valid;
            exp_q  <= rd_exp;
            if (clear) begin
                fail_q <= 1'b0;
            end else if (mismatch) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign fail = fail_q;

`ifdef MARCH_FAIL_LOG_EN
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [CNT_W-1:0]  fail_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            paddr_q     <= '0;
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            paddr_q <= rd_addr;
            if (clear) begin
                fail_addr_q <= '0;
                fail_cnt_q  <= '0;
            end else if (mismatch) begin
                if (!fail_q) begin
                    fail_addr_q <= paddr_q;
                end
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_cnt  = fail_cnt_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign fail_addr      = '0;
    assign fail_cnt       = '0;
`endif

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer for a 16x2 SRAM: one operation per cycle, then DRAIN, then DONE.
// Fail logging detail depends on MARCH_FAIL_LOG_EN (see march_cmp).
module march_bist_ctrl
    import march_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we_n,
    output logic              mem_cs_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt
);

    march_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_phase_q, wr_phase_d;

    logic              two_op;
    logic              at_end;
    logic              start_ok;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_exp;

    assign two_op   = elem_has_read(state_q) && elem_has_write(state_q);
    assign at_end   = elem_down(state_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wr_phase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_phase_q <= wr_phase_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_phase_d = wr_phase_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StM0;
                    addr_d     = '0;
                    wr_phase_d = 1'b0;
                end
            end
            StDrain: state_d = StDone;
            default: begin
                if (two_op && !wr_phase_q) begin
                    wr_phase_d = 1'b1;
                end else begin
                    wr_phase_d = 1'b0;
                    // Element boundary: reload the start address of the next element.
                    if (at_end) begin
                        state_d = next_elem(state_q);
                        addr_d  = elem_down(next_elem(state_q)) ? ADDR_LAST : '0;
                    end else if (elem_down(state_q)) begin
                        addr_d = addr_q - ADDR_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs_n  = 1'b1;
        mem_we_n  = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_valid  = 1'b0;
        rd_exp    = '0;
        case (state_q)
            StIdle:  ;
            StDone:  done = 1'b1;
            StDrain: busy = 1'b1;
            default: begin
                busy     = 1'b1;
                mem_cs_n = 1'b0;
                mem_addr = addr_q;
                if (elem_has_read(state_q) && !(two_op && wr_phase_q)) begin
                    mem_we_n = 1'b1;
                    rd_valid = 1'b1;
                    rd_exp   = read_bg(state_q);
                end else begin
                    mem_we_n  = 1'b0;
                    mem_wdata = write_bg(state_q);
                end
            end
        endcase
    end

    march_cmp u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .rd_valid  (rd_valid),
        .rd_exp    (rd_exp),
        .rd_addr   (mem_addr),
        .mem_rdata (mem_rdata),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_cnt  (fail_cnt)
    );

endmodule
